// File: rtl/irq_line_conditioner.sv
// Conditions external interrupt pins: 2-flop sync, per-line debounce, level or latched-edge request.
// Optional per-line 8-bit saturating rise counters when IRQ_EVENT_COUNT_EN is defined.
module irq_line_conditioner #(
   parameter int unsigned N_LINES         = 7,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned CNT_W           = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_LINES-1:0]     ir_raw,
   input  logic [N_LINES-1:0]     ir_mode,
   input  logic [N_LINES-1:0]     ir_mask,
   input  logic [N_LINES-1:0]     ir_ack,
`ifdef IRQ_EVENT_COUNT_EN
   input  logic [N_LINES-1:0]     ir_cnt_clr,
   output logic [8*N_LINES-1:0]   ir_evt_cnt,
`endif
   output logic [N_LINES-1:0]     ir_out,
   output logic [N_LINES-1:0]     ir_stable,
   output logic [N_LINES-1:0]     ir_pend
);

   typedef enum logic {StIdle, StPend} line_st_e;

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_LINES-1:0] sync1_q, sync2_q;
   logic [N_LINES-1:0] stable_q, stable_d;
   logic [N_LINES-1:0] stable_dly_q;
   logic [N_LINES-1:0] out_q, out_d;
   logic [N_LINES-1:0] rise;
   logic [CNT_W-1:0]   cnt_q [N_LINES];
   logic [CNT_W-1:0]   cnt_d [N_LINES];
   line_st_e           state_q [N_LINES];
   line_st_e           state_d [N_LINES];

   always_comb begin
      rise = stable_q & ~stable_dly_q;
      for (int i = 0; i < N_LINES; i++) begin
         stable_d[i] = stable_q[i];
         cnt_d[i]    = cnt_q[i];
         if (sync2_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntMax) begin
            stable_d[i] = sync2_q[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end

         // A new rise wins over a same-cycle ack; leaving edge mode drops the request.
         state_d[i] = state_q[i];
         unique case (state_q[i])
            StIdle: if (ir_mode[i] && rise[i]) state_d[i] = StPend;
            StPend: if (ir_ack[i] && !rise[i]) state_d[i] = StIdle;
         endcase
         if (!ir_mode[i]) state_d[i] = StIdle;

         out_d[i] = ~ir_mask[i] & (ir_mode[i] ? (state_d[i] == StPend) : stable_q[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         stable_q     <= '0;
         stable_dly_q <= '0;
         out_q        <= '0;
         for (int i = 0; i < N_LINES; i++) begin
            cnt_q[i]   <= '0;
            state_q[i] <= StIdle;
         end
      end else begin
         sync1_q      <= ir_raw;
         sync2_q      <= sync1_q;
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
         out_q        <= out_d;
         for (int i = 0; i < N_LINES; i++) begin
            cnt_q[i]   <= cnt_d[i];
            state_q[i] <= state_d[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N_LINES; i++) begin
         ir_pend[i] = (state_q[i] == StPend);
      end
   end

   assign ir_out    = out_q;
   assign ir_stable = stable_q;

`ifdef IRQ_EVENT_COUNT_EN
   logic [7:0] evt_q [N_LINES];
   logic [7:0] evt_d [N_LINES];

   always_comb begin
      for (int i = 0; i < N_LINES; i++) begin
         evt_d[i] = evt_q[i];
         if (ir_cnt_clr[i]) begin
            evt_d[i] = '0;
         end else if (rise[i] && (evt_q[i] != 8'hff)) begin
            evt_d[i] = evt_q[i] + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_LINES; i++) evt_q[i] <= '0;
      end else begin
         for (int i = 0; i < N_LINES; i++) evt_q[i] <= evt_d[i];
      end
   end

   always_comb begin
      for (int i = 0; i < N_LINES; i++) begin
         ir_evt_cnt[8*i +: 8] = evt_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_irq_line_conditioner.sv
// Directed bench for irq_line_conditioner with a sliding-window behavioural model checked every cycle.
module tb_irq_line_conditioner;

   localparam int NL = 7;
   localparam int DB = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [NL-1:0] ir_raw, ir_mode, ir_mask, ir_ack, ir_cnt_clr;
   logic [NL-1:0] ir_out, ir_stable, ir_pend;
   logic [8*NL-1:0] ir_evt_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   irq_line_conditioner #(
      .N_LINES        (NL),
      .DEBOUNCE_CYCLES(DB),
      .CNT_W          (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ir_raw    (ir_raw),
      .ir_mode   (ir_mode),
      .ir_mask   (ir_mask),
      .ir_ack    (ir_ack),
`ifdef IRQ_EVENT_COUNT_EN
      .ir_cnt_clr(ir_cnt_clr),
      .ir_evt_cnt(ir_evt_cnt),
`endif
      .ir_out    (ir_out),
      .ir_stable (ir_stable),
      .ir_pend   (ir_pend)
   );

`ifndef IRQ_EVENT_COUNT_EN
   assign ir_evt_cnt = '0;
`endif

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: stable flips once the last DB synchronised samples (raw delayed 2) all disagree with it.
   logic [NL-1:0]   m_samp [DB+1];
   logic [NL-1:0]   m_st = '0, m_st_prev = '0, m_pend = '0, m_out = '0;
   logic [8*NL-1:0] m_cnt = '0;

   initial for (int j = 0; j <= DB; j++) m_samp[j] = '0;

   always @(posedge clk or posedge rst) begin : model
      logic [NL-1:0]   st_n, rise, pend_n, out_n;
      logic [8*NL-1:0] cnt_n;
      logic            diff;
      if (rst) begin
         for (int j = 0; j <= DB; j++) m_samp[j] <= '0;
         m_st      <= '0;
         m_st_prev <= '0;
         m_pend    <= '0;
         m_out     <= '0;
         m_cnt     <= '0;
      end else begin
         rise  = m_st & ~m_st_prev;
         cnt_n = m_cnt;
         for (int i = 0; i < NL; i++) begin
            diff = 1'b1;
            for (int j = 1; j <= DB; j++) if (m_samp[j][i] == m_st[i]) diff = 1'b0;
            st_n[i] = diff ? ~m_st[i] : m_st[i];
            if (!ir_mode[i])     pend_n[i] = 1'b0;
            else if (rise[i])    pend_n[i] = 1'b1;
            else if (ir_ack[i])  pend_n[i] = 1'b0;
            else                 pend_n[i] = m_pend[i];
            out_n[i] = ~ir_mask[i] & (ir_mode[i] ? pend_n[i] : m_st[i]);
            if (ir_cnt_clr[i]) cnt_n[8*i +: 8] = 8'd0;
            else if (rise[i] && m_cnt[8*i +: 8] < 8'd255) cnt_n[8*i +: 8] = m_cnt[8*i +: 8] + 8'd1;
         end
         m_samp[0] <= ir_raw;
         for (int j = 1; j <= DB; j++) m_samp[j] <= m_samp[j-1];
         m_st      <= st_n;
         m_st_prev <= m_st;
         m_pend    <= pend_n;
         m_out     <= out_n;
         m_cnt     <= cnt_n;
      end
   end

   always @(negedge clk) begin
      chk("model ir_out", ir_out, m_out);
      chk("model ir_stable", ir_stable, m_st);
      chk("model ir_pend", ir_pend, m_pend);
`ifdef IRQ_EVENT_COUNT_EN
      chk("model ir_evt_cnt", ir_evt_cnt, m_cnt);
`endif
   end

   initial begin
      rst        = 1'b1;
      ir_raw     = '0;
      ir_mode    = 7'b0110100;
      ir_mask    = '0;
      ir_ack     = '0;
      ir_cnt_clr = '0;
      repeat (3) tick();
      chk("reset ir_out", ir_out, 0);
      chk("reset ir_stable", ir_stable, 0);
      chk("reset ir_pend", ir_pend, 0);
      rst = 1'b0;
      repeat (2) tick();

      // Level mode, line 0
      ir_raw[0] = 1'b1;
      repeat (5) tick();
      chk("lvl stable0 c5", ir_stable[0], 0);
      tick();
      chk("lvl stable0 c6", ir_stable[0], 1);
      chk("lvl out0 c6", ir_out[0], 0);
      tick();
      chk("lvl out0 c7", ir_out[0], 1);
      repeat (13) tick();
      ir_raw[0] = 1'b0;
      repeat (6) tick();
      chk("lvl fall stable0 c6", ir_stable[0], 0);
      chk("lvl fall out0 c6", ir_out[0], 1);
      tick();
      chk("lvl fall out0 c7", ir_out[0], 0);

      // Glitches on line 3, with one low sample between bursts
      ir_raw[3] = 1'b1;
      repeat (3) tick();
      ir_raw[3] = 1'b0;
      tick();
      ir_raw[3] = 1'b1;
      repeat (3) tick();
      ir_raw[3] = 1'b0;
      repeat (8) tick();
      chk("glitch stable3", ir_stable[3], 0);
      chk("glitch out3", ir_out[3], 0);

      // Edge mode, line 2
      ir_raw[2] = 1'b1;
      repeat (6) tick();
      chk("edge out2 c6", ir_out[2], 0);
      tick();
      chk("edge out2 c7", ir_out[2], 1);
      repeat (3) tick();
      ir_raw[2] = 1'b0;
      repeat (8) tick();
      chk("edge held stable2", ir_stable[2], 0);
      chk("edge held out2", ir_out[2], 1);
      chk("edge held pend2", ir_pend[2], 1);
      ir_ack[2] = 1'b1;
      tick();
      ir_ack[2] = 1'b0;
      chk("ack out2", ir_out[2], 0);
      chk("ack pend2", ir_pend[2], 0);

      // Rise coinciding with ack keeps the request
      ir_raw[2] = 1'b1;
      repeat (8) tick();
      chk("re-pend2", ir_pend[2], 1);
      ir_raw[2] = 1'b0;
      repeat (8) tick();
      ir_raw[2] = 1'b1;
      repeat (6) tick();
      ir_ack[2] = 1'b1;
      tick();
      ir_ack[2] = 1'b0;
      chk("rise+ack pend2", ir_pend[2], 1);
      chk("rise+ack out2", ir_out[2], 1);
      ir_mask[2] = 1'b1;
      tick();
      chk("mask out2", ir_out[2], 0);
      chk("mask pend2", ir_pend[2], 1);
      ir_mask[2] = 1'b0;
      tick();
      chk("unmask out2", ir_out[2], 1);
      ir_mode[2] = 1'b0;
      tick();
      chk("mode0 drops pend2", ir_pend[2], 0);
      chk("mode0 level out2", ir_out[2], 1);
      ir_mode[2] = 1'b1;
      ir_raw[2]  = 1'b0;
      repeat (8) tick();

      // Asynchronous reset with line 5 pending and line 1 mid-debounce
      ir_raw[5] = 1'b1;
      repeat (8) tick();
      ir_raw[1] = 1'b1;
      repeat (3) tick();
      chk("pre-rst pend5", ir_pend[5], 1);
      #2 rst = 1'b1;
      #1;
      chk("async rst out", ir_out, 0);
      chk("async rst stable", ir_stable, 0);
      chk("async rst pend", ir_pend, 0);
      chk("async rst cnt", ir_evt_cnt, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) tick();
      chk("post-rst stable1 c5", ir_stable[1], 0);
      tick();
      chk("post-rst stable1 c6", ir_stable[1], 1);

`ifdef IRQ_EVENT_COUNT_EN
      // 260 debounced rises on line 4 saturate its counter
      for (int k = 0; k < 260; k++) begin
         ir_raw[4] = 1'b1;
         repeat (5) tick();
         ir_raw[4] = 1'b0;
         repeat (5) tick();
      end
      repeat (4) tick();
      chk("evt cnt4 sat", ir_evt_cnt[39:32], 8'd255);
      ir_raw[4] = 1'b1;
      repeat (6) tick();
      ir_cnt_clr[4] = 1'b1;
      tick();
      ir_cnt_clr[4] = 1'b0;
      chk("evt cnt4 clr wins", ir_evt_cnt[39:32], 8'd0);
`endif

      repeat (4) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
